regfile_wb: RTL and testbench

//  Integer register file plus write-back select for the single-cycle RV64 core.

---
 rtl/regfile_wb_pkg.sv | 20 ++
 rtl/regfile_rport.sv | 27 ++
 rtl/regfile_wb.sv | 121 ++++++++++++
 tb/tb_regfile_wb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared constants and helpers for the integer register file / write-back slice.
package regfile_wb_pkg;

  localparam int unsigned XLEN_DEFAULT   = 64;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned WB_SEL_WIDTH   = 2;

  // Bit positions inside the one-hot write-back select.
  localparam int unsigned WB_SEL_ALU = 0;
  localparam int unsigned WB_SEL_LSU = 1;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [WB_SEL_WIDTH-1:0]   wb_sel_t;

  // A two-bit select is one-hot exactly when its bits differ.
  function automatic logic wb_sel_legal(input wb_sel_t sel);
    return sel[WB_SEL_ALU] ^ sel[WB_SEL_LSU];
  endfunction

endpackage

// File: rtl/regfile_rport.sv
// Combinational register read port: array lookup, optional write bypass, x0 forced to zero.
module regfile_rport
  import regfile_wb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREG = 32
) (
  input  logic [REG_ADDR_WIDTH-1:0] addr_i,
  input  logic [XLEN-1:0]           regs_i [NREG],
  input  logic                      byp_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] byp_addr_i,
  input  logic [XLEN-1:0]           byp_data_i,
  output logic [XLEN-1:0]           rdata_o
);

  // Stored value, overridden by in-flight write data, overridden by the x0 rule.
  always_comb begin
    rdata_o = regs_i[addr_i];
    if (byp_en_i && (byp_addr_i == addr_i)) begin
      rdata_o = byp_data_i;
    end
    if (addr_i == '0) begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// RV64 integer register file with write-back source select, two combinational
// read ports, one registered debug read port and a sticky illegal-select flag.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic [XLEN-1:0]           rs1_rdata_o,
  output logic [XLEN-1:0]           rs2_rdata_o,
  input  logic                      rd_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [WB_SEL_WIDTH-1:0]   wb_sel_i,
  input  logic [XLEN-1:0]           alu_res_i,
  input  logic [XLEN-1:0]           lsu_rdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr_i,
  output logic [XLEN-1:0]           dbg_rdata_o,
  output logic                      wb_err_o
);

  // x0 has no storage; entries 1..NREG-1 only.
  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [XLEN-1:0] regs_d [1:NREG-1];
  // Full-address view with x0 tied to zero, shared by all read paths.
  logic [XLEN-1:0] regs_view [NREG];

  logic [XLEN-1:0] wb_data;
  logic            wr_legal;
  logic            wr_commit;
  logic            byp_en;

  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
  logic            wb_err_q, wb_err_d;

  // Write-back data select and write qualification.
  always_comb begin
    wb_data   = ({XLEN{wb_sel_i[WB_SEL_ALU]}} & alu_res_i)
              | ({XLEN{wb_sel_i[WB_SEL_LSU]}} & lsu_rdata_i);
    wr_legal  = rd_we_i & wb_sel_legal(wb_sel_i);
    wr_commit = wr_legal & (rd_addr_i != '0);
    // Reset is folded in so read ports show the zeroed array while rst_n is low.
    byp_en    = (BYPASS != 0) & wr_legal & rst_n;
  end

  // Address-indexed view of the array with a constant-zero x0.
  always_comb begin
    regs_view[0] = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

  // Next-state of the register array: a single legal write per cycle.
  always_comb begin
    regs_d = regs_q;
    if (wr_commit) begin
      regs_d[rd_addr_i] = wb_data;
    end
  end

  // Debug read (pre-write value, never bypassed) and sticky illegal-select flag.
  always_comb begin
    dbg_rdata_d = regs_view[dbg_addr_i];
    wb_err_d    = wb_err_q | (rd_we_i & ~wb_sel_legal(wb_sel_i));
  end

  // Register array state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Debug data and error flag state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      dbg_rdata_q <= dbg_rdata_d;
      wb_err_q    <= wb_err_d;
    end
  end

  regfile_rport #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rport_rs1 (
    .addr_i     (rs1_addr_i),
    .regs_i     (regs_view),
    .byp_en_i   (byp_en),
    .byp_addr_i (rd_addr_i),
    .byp_data_i (wb_data),
    .rdata_o    (rs1_rdata_o)
  );

  regfile_rport #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rport_rs2 (
    .addr_i     (rs2_addr_i),
    .regs_i     (regs_view),
    .byp_en_i   (byp_en),
    .byp_addr_i (rd_addr_i),
    .byp_data_i (wb_data),
    .rdata_o    (rs2_rdata_o)
  );

  assign dbg_rdata_o = dbg_rdata_q;
  assign wb_err_o    = wb_err_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: one bypassing and one non-bypassing
// instance share stimulus and are checked against an array-based reference.
module tb_regfile_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic        rd_we;
  logic [1:0]  wb_sel;
  logic [63:0] alu_res, lsu_rdata;

  logic [63:0] rs1_a, rs2_a, dbg_a;
  logic        err_a;
  logic [63:0] rs1_b, rs2_b, dbg_b;
  logic        err_b;

  // Reference state
  logic [63:0] mdl [32];
  logic        mdl_err;
  logic [63:0] mdl_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb #(.XLEN(64), .NREG(32), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_rdata_o(rs1_a), .rs2_rdata_o(rs2_a),
    .rd_we_i(rd_we), .rd_addr_i(rd_addr), .wb_sel_i(wb_sel),
    .alu_res_i(alu_res), .lsu_rdata_i(lsu_rdata),
    .dbg_addr_i(dbg_addr), .dbg_rdata_o(dbg_a), .wb_err_o(err_a)
  );

  regfile_wb #(.XLEN(64), .NREG(32), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_rdata_o(rs1_b), .rs2_rdata_o(rs2_b),
    .rd_we_i(rd_we), .rd_addr_i(rd_addr), .wb_sel_i(wb_sel),
    .alu_res_i(alu_res), .lsu_rdata_i(lsu_rdata),
    .dbg_addr_i(dbg_addr), .dbg_rdata_o(dbg_b), .wb_err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit sel_ok();
    return (wb_sel == 2'b01) || (wb_sel == 2'b10);
  endfunction

  function automatic logic [63:0] sel_data();
    return (wb_sel == 2'b01) ? alu_res : lsu_rdata;
  endfunction

  // Expected combinational read for the current inputs.
  function automatic logic [63:0] exp_rs(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 64'd0;
    if (byp && rst_n && rd_we && sel_ok() && rd_addr == a) return sel_data();
    return mdl[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    mdl_err = 1'b0;
    mdl_dbg = 64'd0;
  endtask

  // Advance one clock and update the reference from the inputs seen at the edge.
  task automatic cycle();
    logic [63:0] nd;
    nd = mdl[dbg_addr];
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      mdl_dbg = nd;
      if (rd_we && sel_ok() && rd_addr != 5'd0) mdl[rd_addr] = sel_data();
      if (rd_we && !sel_ok()) mdl_err = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rd_we = 1'b0; rd_addr = 5'd0; wb_sel = 2'b01;
    alu_res = 64'd0; lsu_rdata = 64'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (3) cycle();
    n_checks++; if (err_a !== 1'b0 || dbg_a !== 64'd0) begin n_fail++; $display("FAIL reset_hold: err %b dbg %h expected 0 0", err_a, dbg_a); end
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a); dbg_addr = 5'(a);
      #1;
      n_checks++; if (rs1_a !== 64'd0 || rs1_b !== 64'd0) begin n_fail++; $display("FAIL reset_rs1[%0d]: got %h/%h expected 0", a, rs1_a, rs1_b); end
      n_checks++; if (rs2_a !== 64'd0 || rs2_b !== 64'd0) begin n_fail++; $display("FAIL reset_rs2[%0d]: got %h/%h expected 0", 31 - a, rs2_a, rs2_b); end
      cycle();
      n_checks++; if (dbg_a !== 64'd0 || dbg_b !== 64'd0) begin n_fail++; $display("FAIL reset_dbg[%0d]: got %h/%h expected 0", a, dbg_a, dbg_b); end
    end
    n_checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b/%b expected 0", err_a, err_b); end
  endtask

  task automatic test_alu_write();
    idle_inputs();
    rd_we = 1'b1; rd_addr = 5'd5; wb_sel = 2'b01; alu_res = 64'h0123_4567_89AB_CDEF;
    lsu_rdata = 64'h5555_5555_5555_5555; rs1_addr = 5'd5; dbg_addr = 5'd5;
    cycle();
    rd_we = 1'b0;
    #1;
    n_checks++; if (rs1_a !== 64'h0123_4567_89AB_CDEF || rs1_b !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL alu_rs1: got %h/%h expected 0123456789abcdef", rs1_a, rs1_b); end
    n_checks++; if (dbg_a !== 64'd0) begin n_fail++; $display("FAIL alu_dbg_prewrite: got %h expected 0", dbg_a); end
    cycle();
    n_checks++; if (dbg_a !== 64'h0123_4567_89AB_CDEF || dbg_b !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL alu_dbg: got %h/%h expected 0123456789abcdef", dbg_a, dbg_b); end
  endtask

  task automatic test_x0_write();
    idle_inputs();
    rd_we = 1'b1; rd_addr = 5'd0; wb_sel = 2'b10; lsu_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    n_checks++; if (rs1_a !== 64'd0 || rs1_b !== 64'd0) begin n_fail++; $display("FAIL x0_same: got %h/%h expected 0", rs1_a, rs1_b); end
    cycle();
    rd_we = 1'b0;
    #1;
    n_checks++; if (rs1_a !== 64'd0 || rs1_b !== 64'd0) begin n_fail++; $display("FAIL x0_after: got %h/%h expected 0", rs1_a, rs1_b); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL x0_err: got %b expected 0", err_a); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    rd_we = 1'b1; rd_addr = 5'd7; wb_sel = 2'b01; alu_res = 64'hDEAD;
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    n_checks++; if (rs1_a !== 64'hDEAD || rs2_a !== 64'hDEAD) begin n_fail++; $display("FAIL byp_on: got %h/%h expected dead", rs1_a, rs2_a); end
    n_checks++; if (rs1_b !== 64'd0 || rs2_b !== 64'd0) begin n_fail++; $display("FAIL byp_off_old: got %h/%h expected 0", rs1_b, rs2_b); end
    cycle();
    rd_we = 1'b0;
    #1;
    n_checks++; if (rs1_b !== 64'hDEAD || rs2_b !== 64'hDEAD) begin n_fail++; $display("FAIL byp_off_new: got %h/%h expected dead", rs1_b, rs2_b); end
  endtask

  task automatic test_illegal_sel();
    idle_inputs();
    rd_we = 1'b1; rd_addr = 5'd3; wb_sel = 2'b11; alu_res = 64'h1111; lsu_rdata = 64'h2222;
    rs1_addr = 5'd3;
    #1;
    n_checks++; if (rs1_a !== 64'd0) begin n_fail++; $display("FAIL ill_nobyp: got %h expected 0", rs1_a); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL ill_err_early: got %b expected 0", err_a); end
    cycle();
    rd_we = 1'b0; wb_sel = 2'b01;
    #1;
    n_checks++; if (err_a !== 1'b1 || err_b !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b/%b expected 1", err_a, err_b); end
    n_checks++; if (rs1_a !== 64'd0 || rs1_b !== 64'd0) begin n_fail++; $display("FAIL ill_x3: got %h/%h expected 0", rs1_a, rs1_b); end
    repeat (4) cycle();
    n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL ill_sticky: got %b expected 1", err_a); end
  endtask

  task automatic test_random();
    logic [63:0] e1a, e2a, e1b, e2b;
    for (int n = 0; n < 400; n++) begin
      rd_we = ($urandom_range(0, 3) != 0);
      rd_addr = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0:       wb_sel = 2'b00;
        1:       wb_sel = 2'b11;
        default: wb_sel = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      endcase
      alu_res = {$urandom, $urandom};
      lsu_rdata = {$urandom, $urandom};
      rs1_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      dbg_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      #1;
      e1a = exp_rs(rs1_addr, 1'b1); e2a = exp_rs(rs2_addr, 1'b1);
      e1b = exp_rs(rs1_addr, 1'b0); e2b = exp_rs(rs2_addr, 1'b0);
      n_checks++; if (rs1_a !== e1a) begin n_fail++; $display("FAIL rnd_rs1_byp[%0d]: got %h expected %h", n, rs1_a, e1a); end
      n_checks++; if (rs2_a !== e2a) begin n_fail++; $display("FAIL rnd_rs2_byp[%0d]: got %h expected %h", n, rs2_a, e2a); end
      n_checks++; if (rs1_b !== e1b) begin n_fail++; $display("FAIL rnd_rs1_nobyp[%0d]: got %h expected %h", n, rs1_b, e1b); end
      n_checks++; if (rs2_b !== e2b) begin n_fail++; $display("FAIL rnd_rs2_nobyp[%0d]: got %h expected %h", n, rs2_b, e2b); end
      cycle();
      n_checks++; if (dbg_a !== mdl_dbg || dbg_b !== mdl_dbg) begin n_fail++; $display("FAIL rnd_dbg[%0d]: got %h/%h expected %h", n, dbg_a, dbg_b, mdl_dbg); end
      n_checks++; if (err_a !== mdl_err || err_b !== mdl_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b/%b expected %b", n, err_a, err_b, mdl_err); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] v;
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      rd_we = 1'b1; rd_addr = 5'(i); wb_sel = 2'b01;
      alu_res = 64'hA5A5_0000_0000_0000 | 64'(i * 257);
      cycle();
    end
    // a legal load write is pending when reset hits mid-cycle
    rd_we = 1'b1; rd_addr = 5'd4; wb_sel = 2'b10; lsu_rdata = 64'hCAFE_F00D_1234_5678;
    #3;
    rst_n = 1'b0;
    model_clear();
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      n_checks++; if (rs1_a !== 64'd0 || rs1_b !== 64'd0 || rs2_a !== 64'd0 || rs2_b !== 64'd0) begin n_fail++; $display("FAIL midrst_rd[%0d]: got %h %h %h %h expected 0", a, rs1_a, rs1_b, rs2_a, rs2_b); end
    end
    n_checks++; if (err_a !== 1'b0 || err_b !== 1'b0 || dbg_a !== 64'd0) begin n_fail++; $display("FAIL midrst_state: err %b/%b dbg %h expected 0", err_a, err_b, dbg_a); end
    // release mid-cycle with a write in the same cycle
    @(negedge clk);
    v = {$urandom, $urandom};
    rd_we = 1'b1; rd_addr = 5'd9; wb_sel = 2'b01; alu_res = v;
    rst_n = 1'b1;
    cycle();
    rd_we = 1'b0; rs1_addr = 5'd9; rs2_addr = 5'd4;
    #1;
    n_checks++; if (rs1_a !== v || rs1_b !== v) begin n_fail++; $display("FAIL release_write: got %h/%h expected %h", rs1_a, rs1_b, v); end
    n_checks++; if (rs2_a !== 64'd0 || rs2_b !== 64'd0) begin n_fail++; $display("FAIL release_x4: got %h/%h expected 0", rs2_a, rs2_b); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL release_err: got %b expected 0", err_a); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    test_reset();
    test_alu_write();
    test_x0_write();
    test_bypass();
    test_illegal_sel();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
